// File: rtl/parity_frame_pkg.sv
// Shared definitions for the masked-parity frame format (receiver and transmitter).
package parity_frame_pkg;

  // Receiver FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle   = 2'd0;
  localparam state_t StData   = 2'd1;
  localparam state_t StParity = 2'd2;
  localparam state_t StStop   = 2'd3;

  // Default parity coverage: data bits 0, 2, 4, 6
  localparam logic [7:0] DEF_PARITY_MASK = 8'h55;

  // Parity over the mask-selected bits; odd inverts the even result.
  function automatic logic masked_parity(input logic [15:0] data,
                                         input logic [15:0] mask,
                                         input logic        odd);
    return (^(data & mask)) ^ odd;
  endfunction

endpackage

// File: rtl/parity_frame_rx.sv
// Serial receiver and masked-parity checker.
// Frame: start(0), DATA_W data bits LSB first, parity bit, stop(1), one bit per bit_en strobe.
// Optional build macro PARITY_FRAME_RX_ERRCNT_EN adds err_clr / err_count (saturating
// errored-frame counter for the diagnostic LED bank).
module parity_frame_rx
  import parity_frame_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter logic [15:0] PARITY_MASK = 16'(DEF_PARITY_MASK),
  parameter bit          PARITY_ODD  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_in,
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  input  logic              err_clr,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_q;
  logic                last_bit;
  logic                calc_par;

  assign last_bit = (idx_q == IDX_W'(DATA_W - 1));
  assign calc_par = masked_parity(16'(shift_q), PARITY_MASK, PARITY_ODD);

  // Deframing FSM: state only advances on bit_en, so gaps between strobes hold everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else if (bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_in) begin
            state_q <= StData;
            idx_q   <= '0;
          end
        end
        StData: begin
          shift_q[idx_q] <= rx_in;
          if (last_bit) begin
            state_q <= StParity;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StParity: begin
          par_q   <= rx_in;
          state_q <= StStop;
        end
        StStop: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Result registers: loaded on the stop-bit strobe, held until the next frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_en && (state_q == StStop)) begin
        data_out   <= shift_q;
        data_valid <= 1'b1;
        parity_err <= par_q ^ calc_par;
        frame_err  <= ~rx_in;
      end
    end
  end

`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [7:0] err_q;

  // Errored-frame counter: counts during the data_valid cycle, saturates, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'd0;
    end else if (err_clr) begin
      err_q <= 8'd0;
    end else if (data_valid && (parity_err || frame_err) && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed self-checking bench for parity_frame_rx (default parameters).
module tb_parity_frame_rx;

  logic       clk;
  logic       rst_n;
  logic       bit_en;
  logic       rx_in;
  logic       err_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] err_count;

  int checks = 0;
  int fails  = 0;
  int dv_cnt = 0;
  int dv_base;

  parity_frame_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .rx_in      (rx_in),
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    .err_clr    (err_clr),
`endif
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

`ifndef PARITY_FRAME_RX_ERRCNT_EN
  assign err_count = 8'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each negedge with data_valid high is one cycle of pulse
  always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe per bit; slow mode leaves an idle cycle between strobes
  task automatic send_bit(input logic b, input bit fast);
    @(negedge clk);
    rx_in  = b;
    bit_en = 1'b1;
    if (!fast) begin
      @(negedge clk);
      bit_en = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input bit fast, input bit clr_at_end);
    send_bit(1'b0, fast);
    for (int i = 0; i < 8; i++) send_bit(d[i], fast);
    send_bit(par, fast);
    send_bit(stop, fast);
    if (fast) begin
      @(negedge clk);
      bit_en = 1'b0;
    end
    // now in the data_valid cycle
    err_clr = clr_at_end;
    rx_in   = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    bit_en  = 1'b0;
    rx_in   = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 8'h00);
    check("reset_valid", data_valid, 1'b0);
    check("reset_parity_err", parity_err, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x15: masked bits 0,2,4 set -> even parity bit 1
    dv_base = dv_cnt;
    send_frame(8'h15, 1'b1, 1'b1, 1'b0, 1'b0);
    check("good_dv_count", dv_cnt - dv_base, 1);
    check("good_data", data_out, 8'h15);
    check("good_parity_err", parity_err, 1'b0);
    check("good_frame_err", frame_err, 1'b0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    check("good_err_count", err_count, 8'd0);
`endif

    // Wrong parity bit
    dv_base = dv_cnt;
    send_frame(8'h15, 1'b0, 1'b1, 1'b0, 1'b0);
    check("perr_dv_count", dv_cnt - dv_base, 1);
    check("perr_data", data_out, 8'h15);
    check("perr_parity_err", parity_err, 1'b1);
    check("perr_frame_err", frame_err, 1'b0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    check("perr_err_count", err_count, 8'd1);
`endif

    // 0xAA: no masked bits -> parity 0 correct; stop bit 0
    dv_base = dv_cnt;
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_dv_count", dv_cnt - dv_base, 1);
    check("ferr_data", data_out, 8'hAA);
    check("ferr_parity_err", parity_err, 1'b0);
    check("ferr_frame_err", frame_err, 1'b1);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    check("ferr_err_count", err_count, 8'd2);
`endif

    // Glitch: line low only between strobes
    dv_base = dv_cnt;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx_in  = 1'b1;
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      rx_in  = 1'b0;
      @(negedge clk);
      rx_in  = 1'b1;
    end
    repeat (2) @(negedge clk);
    check("glitch_dv_count", dv_cnt - dv_base, 0);
    check("glitch_data_hold", data_out, 8'hAA);
    check("glitch_frame_err_hold", frame_err, 1'b1);

    // Back-to-back frames on consecutive-cycle strobes
    // 0x01 -> parity 1; 0x80 -> parity 0
    dv_base = dv_cnt;
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(i == 0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_frame(8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_dv_count", dv_cnt - dv_base, 2);
    check("b2b_data", data_out, 8'h80);
    check("b2b_parity_err", parity_err, 1'b0);
    check("b2b_frame_err", frame_err, 1'b0);

    // Reset after 4 data bits, then clean 0x3C (masked bits 2,4 -> parity 0)
    dv_base = dv_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_data", data_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("midreset_dv_count", dv_cnt - dv_base, 1);
    check("midreset_data_3c", data_out, 8'h3C);
    check("midreset_parity_err", parity_err, 1'b0);
    check("midreset_frame_err", frame_err, 1'b0);

`ifdef PARITY_FRAME_RX_ERRCNT_EN
    check("cnt_after_reset", err_count, 8'd0);
    for (int i = 0; i < 256; i++) send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("cnt_saturated", err_count, 8'd255);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("cnt_clear_wins", err_count, 8'd0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial receiver and parity checker for the masked-parity frame format used by the board I/O path. It samples a one-bit serial line on a bit-rate strobe and deframes start/data/parity/stop. It then recomputes parity over the mask-selected data bits and presents the byte with parity and framing error flags. An optional saturating error counter drives a diagnostic LED bank.

## Interface
- DATA_W, 8, data bits per frame (1..16).
- PARITY_MASK, 8'h55, data bits covered by parity; default covers bits 0, 2, 4, 6.
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of masked bits), 1 = odd (its inverse).
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- bit_en  input  1  one-cycle strobe, one per bit period; rx_in is sampled only when high.
- rx_in  input  1  serial line, idle high.
- err_clr  input  1  synchronous clear of err_count (present only with counter compiled in).
- data_out  output  DATA_W  last received data word, LSB first on the line.
- data_valid  output  1  one-cycle pulse: frame complete; data_out and flags are valid.
- parity_err  output  1  received parity bit ≠ computed parity for last frame.
- frame_err  output  1  stop bit sampled 0 for last frame.
- err_count  output  8  saturating count of errored frames (counter build only).

## Operation
- Frame: start (0), DATA_W data bits LSB first, parity bit, stop (1). Bits arrive on successive bit_en strobes.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on bit_en with rx_in=0, go to DATA with bit index 0. A sample of rx_in=1 stays in IDLE.
  - DATA: on each bit_en, shift rx_in into shift register position index. After bit DATA_W-1, go to PARITY.
  - PARITY: on bit_en, capture the parity bit and go to STOP.
  - STOP: on bit_en, sample the stop bit, load outputs, return to IDLE.
- Cycles without bit_en hold all state. Gaps between strobes are arbitrary.
- Computed parity = XOR(shift & PARITY_MASK) XOR PARITY_ODD.
- parity_err = received parity bit XOR computed parity.
- frame_err = ~stop bit. The data word and parity_err are still reported on a framing error.
- data_out, parity_err and frame_err hold until the next frame completes.
- Back-to-back frames: a start bit on the strobe immediately after STOP is accepted.
- Reset mid-frame: async return to IDLE. The partial frame is discarded and no data_valid is issued.

## Timing
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, err_count=0, FSM=IDLE.
- data_valid is asserted in the clock cycle after the stop-bit bit_en edge and lasts exactly one cycle. Outputs update on the same edge.
- Minimum frame length: DATA_W+3 strobes. Strobes are assumed at least 1 clock apart; consecutive-cycle strobes are legal.
- Latency from stop-bit sample to data_valid: 1 clock.

## Configuration
- PARITY_FRAME_RX_ERRCNT_EN defined: err_count and err_clr exist.
  - err_count increments by 1 on data_valid when parity_err|frame_err, and saturates at 255.
  - err_clr forces 0; clear wins over a simultaneous increment.
- Not defined: neither port exists and no counter logic is generated.

## Structure
- Shared package parity_frame_pkg holds:
  - the FSM state enum;
  - the default mask constant 8'h55;
  - a function computing masked parity, shared with the frame transmitter.
- No sub-module is required. The bit-index counter and shift register stay inline.

## Test plan
- Frame data 0x15, parity bit 1, stop 1 (defaults) -> data_valid once, data_out=0x15, parity_err=0, frame_err=0.
- Frame data 0x15, parity bit 0 -> parity_err=1. With counter enabled, err_count 0->1.
- Frame data 0xAA (no masked bits set), parity 0, stop bit 0 -> data_out=0xAA, parity_err=0, frame_err=1.
- Glitch: rx_in=0 between strobes but 1 at every bit_en -> FSM stays IDLE, no data_valid.
- rst_n pulsed low after 4 data bits, then a clean 0x3C frame -> only one data_valid, data_out=0x3C.
- 256 consecutive errored frames, then err_clr asserted in the same cycle as a 257th error's data_valid -> err_count reads 255, then 0.
